cache_line_mem: RTL

Backing-memory responder that sits on the memory side of the set-associative cache and services line fills (reads) and line write-backs (writes). Traffic is whole 32-byte lines: 8 x 32-bit words, with the line offset in address[4:0] and the set index in address[9:5]. A request handshake starts a programmable access latency, followed by an 8-beat burst.

---
 rtl/cache_line_mem.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cache_line_mem.sv
// Backing-memory responder for cache line fills and write-backs: request handshake,
// programmable access latency, then an 8-beat burst. Optional macro: MEM_OOR_ERR_EN.
module cache_line_mem #(
  parameter int MEM_WORDS  = 1024,
  parameter int LINE_WORDS = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic        wdata_valid,
  input  logic [31:0] wdata,
  output logic        wdata_ready,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        rdata_last,
  output logic        busy
`ifdef MEM_OOR_ERR_EN
  ,
  output logic        resp_err
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [26:0]     line_q;
  logic            write_q;
  logic            err_q;
  logic [LW-1:0]   lat_q;
  logic [BW-1:0]   beat_q;
  logic [BW-1:0]   rd_beat;
  logic [31:0]     rd_q;
  logic [31:0]     mem [MEM_WORDS];

  logic            accept;
  logic            rd_en;
  logic            wr_en;
  logic            beat_inc;
  logic            oor_req;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   wr_idx;
  logic            unused_addr;

  assign unused_addr = ^req_addr[4:0];

`ifdef MEM_OOR_ERR_EN
  assign oor_req = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
`else
  assign oor_req = 1'b0;
`endif

  // Word index is {line, beat} truncated to the storage depth, so high lines wrap.
  assign rd_idx = AW'({line_q, rd_beat});
  assign wr_idx = AW'({line_q, beat_q});

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    beat_inc  = 1'b0;
    rd_beat   = beat_q + BW'(1);
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          if (write_q) begin
            state_nxt = WR_BURST;
          end else begin
            // Prefetch beat 0 so its data lines up with the first rdata_valid cycle.
            state_nxt = RD_BURST;
            rd_en     = 1'b1;
            rd_beat   = '0;
          end
        end
      end
      RD_BURST: begin
        beat_inc = 1'b1;
        if (beat_q == BW'(LINE_WORDS - 1)) begin
          state_nxt = IDLE;
        end else begin
          rd_en = 1'b1;
        end
      end
      WR_BURST: begin
        if (wdata_valid) begin
          beat_inc = 1'b1;
          wr_en    = !err_q;
          if (beat_q == BW'(LINE_WORDS - 1)) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      line_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      lat_q   <= '0;
      beat_q  <= '0;
      rd_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        line_q  <= req_addr[31:5];
        write_q <= req_write;
        err_q   <= oor_req;
        lat_q   <= LW'(LATENCY - 1);
      end
      if (state == WAIT) begin
        beat_q <= '0;
        if (lat_q != '0) begin
          lat_q <= lat_q - LW'(1);
        end
      end else if (beat_inc) begin
        beat_q <= beat_q + BW'(1);
      end
      if (rd_en) begin
        rd_q <= err_q ? '0 : mem[rd_idx];
      end
    end
  end

  // Storage is not reset; a write on a reset edge is dropped with the abandoned burst.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_idx] <= wdata;
    end
  end

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign wdata_ready = (state == WR_BURST);
  assign rdata_valid = (state == RD_BURST);
  assign rdata       = (state == RD_BURST) ? rd_q : '0;
  assign rdata_last  = (state == RD_BURST) && (beat_q == BW'(LINE_WORDS - 1));

`ifdef MEM_OOR_ERR_EN
  assign resp_err = err_q && ((state == RD_BURST) || ((state == WR_BURST) && wdata_valid));
`endif

endmodule
